// File: rtl/rwc_pkg.sv
// Shared types and helpers for the read-write-collision voting controller.
// Optional feature macro used by this slice: RWC_UNSTABLE_MASK_EN.
package rwc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SAMP_W,
        CLEAR,
        SAMP_C,
        VOTE,
        HOLD
    } rwc_state_t;

    localparam logic CLEAR_BIT_DEFAULT = 1'b0;

    // Wide enough to count every round of a challenge, including the all-ones case.
    function automatic int cnt_width(input int rounds);
        return $clog2(rounds + 1);
    endfunction

endpackage

// File: rtl/rwc_vote_acc.sv
// Per-bit vote counters with clear/accumulate and combinational majority decision.
// RWC_UNSTABLE_MASK_EN adds the per-bit disagreement output.
import rwc_pkg::*;

module rwc_vote_acc #(
    parameter int DATA_W     = 32,
    parameter int NUM_ROUNDS = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic [DATA_W-1:0] din_i,
`ifdef RWC_UNSTABLE_MASK_EN
    output logic [DATA_W-1:0] unstable_o,
`endif
    output logic [DATA_W-1:0] vote_o
);

    localparam int              CW    = cnt_width(NUM_ROUNDS);
    localparam logic [CW:0]     MAJ_T = NUM_ROUNDS[CW:0];
    localparam logic [CW-1:0]   ALL_C = NUM_ROUNDS[CW-1:0];

    logic [CW-1:0] cnt_q [DATA_W];
    logic [CW-1:0] cnt_d [DATA_W];

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (acc_i) begin
                cnt_d[i] = cnt_q[i] + CW'(din_i[i]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DATA_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Majority: twice the count of ones exceeds the (odd) number of rounds.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            vote_o[i] = {cnt_q[i], 1'b0} > MAJ_T;
        end
    end

`ifdef RWC_UNSTABLE_MASK_EN
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            unstable_o[i] = (cnt_q[i] != '0) && (cnt_q[i] != ALL_C);
        end
    end
`endif

endmodule

// File: rtl/rwc_vote_ctrl.sv
// RWC PUF controller: repeats write/read/clear/read collisions and majority-votes the samples.
// RWC_UNSTABLE_MASK_EN adds the rsp_unstable_o disagreement mask.
import rwc_pkg::*;

module rwc_vote_ctrl #(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 10,
    parameter int                NUM_ROUNDS    = 5,
    parameter int                RD_LAT        = 1,
    parameter logic [DATA_W-1:0] CLEAR_PATTERN = {DATA_W{CLEAR_BIT_DEFAULT}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] cha_addr_i,
    input  logic [DATA_W-1:0] cha_data_i,
    input  logic              abort_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_write_o,
    output logic [DATA_W-1:0] rsp_clean_o,
`ifdef RWC_UNSTABLE_MASK_EN
    output logic [DATA_W-1:0] rsp_unstable_o,
`endif
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    input  logic [DATA_W-1:0] bram_dout_i
);

    if (NUM_ROUNDS < 1 || (NUM_ROUNDS % 2) == 0) begin : g_bad_rounds
        $error("rwc_vote_ctrl: NUM_ROUNDS must be odd and at least 1");
    end
    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("rwc_vote_ctrl: RD_LAT must be 1 or 2");
    end

    localparam int            RW         = cnt_width(NUM_ROUNDS);
    localparam int            LR         = NUM_ROUNDS - 1;
    localparam logic [RW-1:0] LAST_ROUND = LR[RW-1:0];
    localparam int            LL         = RD_LAT - 1;
    localparam logic          LAT_LAST   = LL[0];

    rwc_state_t        state_q, state_d;
    logic [RW-1:0]     round_q, round_d;
    logic              lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_write_q, rsp_clean_q;
    logic              we_pos_q, we_neg_q;
    logic              samp_last, vote_clr, acc_w, acc_c, do_vote;
    logic [DATA_W-1:0] vote_w, vote_c;

    assign samp_last = (lat_q == LAT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = WRITE;
            WRITE:   state_d = SAMP_W;
            SAMP_W:  if (samp_last) state_d = CLEAR;
            CLEAR:   state_d = SAMP_C;
            SAMP_C:  if (samp_last) state_d = (round_q == LAST_ROUND) ? VOTE : WRITE;
            VOTE:    state_d = HOLD;
            HOLD:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ready_o     = (state_q == IDLE);
        rsp_valid_o = (state_q == HOLD);
        vote_clr    = (state_q == IDLE) && start_i;
        acc_w       = (state_q == SAMP_W) && samp_last && !abort_i;
        acc_c       = (state_q == SAMP_C) && samp_last && !abort_i;
        do_vote     = (state_q == VOTE) && !abort_i;
        bram_din_o  = '0;
        if (state_q == WRITE) begin
            bram_din_o = data_q;
        end else if (state_q == CLEAR) begin
            bram_din_o = CLEAR_PATTERN;
        end
    end

    always_comb begin
        round_d = round_q;
        if (vote_clr) begin
            round_d = '0;
        end else if (acc_c && round_q != LAST_ROUND) begin
            round_d = round_q + RW'(1);
        end
        lat_d = ((state_q == SAMP_W || state_q == SAMP_C) && !samp_last && !abort_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            round_q     <= '0;
            lat_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_write_q <= '0;
            rsp_clean_q <= '0;
        end else begin
            round_q <= round_d;
            lat_q   <= lat_d;
            if (vote_clr) begin
                addr_q <= cha_addr_i;
                data_q <= cha_data_i;
            end
            if (do_vote) begin
                rsp_write_q <= vote_w;
                rsp_clean_q <= vote_c;
            end
        end
    end

    // Write pulse covers only the first half-cycle: the rising edge arms it, the next falling edge disarms it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_pos_q <= 1'b0;
        end else if (state_d == WRITE || state_d == CLEAR) begin
            we_pos_q <= ~we_pos_q;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_neg_q <= 1'b0;
        end else begin
            we_neg_q <= we_pos_q;
        end
    end

    assign bram_we_o   = we_pos_q ^ we_neg_q;
    assign bram_addr_o = addr_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_clean_o = rsp_clean_q;

`ifdef RWC_UNSTABLE_MASK_EN
    logic [DATA_W-1:0] unst_w, unst_c, rsp_unstable_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_unstable_q <= '0;
        end else if (do_vote) begin
            rsp_unstable_q <= unst_w | unst_c;
        end
    end

    assign rsp_unstable_o = rsp_unstable_q;
`endif

    rwc_vote_acc #(.DATA_W(DATA_W), .NUM_ROUNDS(NUM_ROUNDS)) u_acc_write (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (vote_clr),
        .acc_i      (acc_w),
        .din_i      (bram_dout_i),
`ifdef RWC_UNSTABLE_MASK_EN
        .unstable_o (unst_w),
`endif
        .vote_o     (vote_w)
    );

    rwc_vote_acc #(.DATA_W(DATA_W), .NUM_ROUNDS(NUM_ROUNDS)) u_acc_clean (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (vote_clr),
        .acc_i      (acc_c),
        .din_i      (bram_dout_i),
`ifdef RWC_UNSTABLE_MASK_EN
        .unstable_o (unst_c),
`endif
        .vote_o     (vote_c)
    );

endmodule

// File: tb/tb_rwc_vote_ctrl.sv
// Directed bench for rwc_vote_ctrl with a collision-returns-new-data BRAM model and per-read bit flips.
module tb_rwc_vote_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [AW-1:0] chaAddr = '0;
    logic [DW-1:0] chaData = '0;
    logic          abort = 1'b0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [DW-1:0] rspWrite;
    logic [DW-1:0] rspClean;
`ifdef RWC_UNSTABLE_MASK_EN
    logic [DW-1:0] rspUnstable;
`endif
    logic          bramWe;
    logic [AW-1:0] bramAddr;
    logic [DW-1:0] bramDin;
    logic [DW-1:0] bramDout = '0;

    int checks = 0;
    int errors = 0;
    int lat;
    logic seenValid;
    logic seenWe;

    logic [DW-1:0] mem [1024];
    int            pulseCnt = 0;
    int            basePulse = 0;
    logic [DW-1:0] writeFlip [5];
    logic [DW-1:0] cleanFlip [5];

    rwc_vote_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .ready_o        (ready),
        .cha_addr_i     (chaAddr),
        .cha_data_i     (chaData),
        .abort_i        (abort),
        .rsp_valid_o    (rspValid),
        .rsp_ready_i    (rspReady),
        .rsp_write_o    (rspWrite),
        .rsp_clean_o    (rspClean),
`ifdef RWC_UNSTABLE_MASK_EN
        .rsp_unstable_o (rspUnstable),
`endif
        .bram_we_o      (bramWe),
        .bram_addr_o    (bramAddr),
        .bram_din_o     (bramDin),
        .bram_dout_i    (bramDout)
    );

    always #5 clk = ~clk;

    // Odd pulses of a challenge are challenge writes, even pulses are clear writes.
    function automatic logic [DW-1:0] flipMask(input int idx);
        if (idx < 1 || idx > 10) return '0;
        if (idx % 2 == 1) return writeFlip[(idx - 1) / 2];
        return cleanFlip[idx / 2 - 1];
    endfunction

    always @(posedge clk) begin
        bramDout <= mem[bramAddr] ^ flipMask(pulseCnt - basePulse);
    end

    always @(posedge clk) begin
        #2;
        if (bramWe === 1'b1) begin
            mem[bramAddr] = bramDin;
            pulseCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearFlips();
        for (int i = 0; i < 5; i++) begin
            writeFlip[i] = '0;
            cleanFlip[i] = '0;
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        basePulse = pulseCnt;
        chaAddr   = a;
        chaData   = d;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        chaData = ~d;
        chaAddr = ~a;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (rspValid !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        checkOutput("ready_after_hs", 32'(ready), 32'd1);
        checkOutput("valid_after_hs", 32'(rspValid), 32'd0);
    endtask

    initial begin
        clearFlips();
        #2;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_write", rspWrite, 32'd0);
        checkOutput("rst_clean", rspClean, 32'd0);
        checkOutput("rst_we", 32'(bramWe), 32'd0);
        checkOutput("rst_din", bramDin, 32'd0);
        checkOutput("rst_addr", 32'(bramAddr), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Clean collision, no flips
        applyStimulus(10'h3F, 32'hA5A5_5A5A);
        checkOutput("t1_we_high", 32'(bramWe), 32'd1);
        checkOutput("t1_din", bramDin, 32'hA5A5_5A5A);
        checkOutput("t1_addr", 32'(bramAddr), 32'h3F);
        checkOutput("t1_ready_busy", 32'(ready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t1_we_low_half", 32'(bramWe), 32'd0);
        @(posedge clk);
        #1;
        lat = 1;
        while (rspValid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t1_latency", 32'(lat), 32'd21);
        checkOutput("t1_write", rspWrite, 32'hA5A5_5A5A);
        checkOutput("t1_clean", rspClean, 32'h0);
`ifdef RWC_UNSTABLE_MASK_EN
        checkOutput("t1_unstable", rspUnstable, 32'h0);
`endif
        handshake();

        // Bit 0 disturbed in 2 of 5 write reads
        clearFlips();
        writeFlip[1] = 32'h1;
        writeFlip[3] = 32'h1;
        applyStimulus(10'h3F, 32'h1234_5679);
        waitValid(lat);
        checkOutput("t2_latency", 32'(lat), 32'd21);
        checkOutput("t2_write", rspWrite, 32'h1234_5679);
        checkOutput("t2_clean", rspClean, 32'h0);
`ifdef RWC_UNSTABLE_MASK_EN
        checkOutput("t2_unstable", rspUnstable, 32'h1);
`endif
        handshake();

        // Bit 7 disturbed in 3 of 5 clean reads, then held response with start ignored
        clearFlips();
        cleanFlip[0] = 32'h80;
        cleanFlip[2] = 32'h80;
        cleanFlip[4] = 32'h80;
        applyStimulus(10'h100, 32'hFFFF_0000);
        waitValid(lat);
        checkOutput("t3_latency", 32'(lat), 32'd21);
        checkOutput("t3_write", rspWrite, 32'hFFFF_0000);
        checkOutput("t3_clean", rspClean, 32'h80);
`ifdef RWC_UNSTABLE_MASK_EN
        checkOutput("t3_unstable", rspUnstable, 32'h80);
`endif
        clearFlips();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start   = 1'b1;
            chaData = 32'h0BAD_0000 + 32'(c);
            @(posedge clk);
            #1;
            checkOutput("t4_hold_valid", 32'(rspValid), 32'd1);
            checkOutput("t4_hold_ready", 32'(ready), 32'd0);
            checkOutput("t4_hold_write", rspWrite, 32'hFFFF_0000);
            checkOutput("t4_hold_clean", rspClean, 32'h80);
        end
        @(negedge clk);
        start = 1'b0;
        handshake();
        @(posedge clk);
        #1;
        checkOutput("t4_still_idle", 32'(ready), 32'd1);

        // Abort mid-challenge while a new write would otherwise start
        applyStimulus(10'h155, 32'h0F0F_0F0F);
        repeat (7) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("t5_we_low", 32'(bramWe), 32'd0);
        checkOutput("t5_ready", 32'(ready), 32'd1);
        seenValid = 1'b0;
        seenWe    = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (rspValid !== 1'b0) seenValid = 1'b1;
            if (bramWe !== 1'b0) seenWe = 1'b1;
        end
        checkOutput("t5_no_valid", 32'(seenValid), 32'd0);
        checkOutput("t5_no_we", 32'(seenWe), 32'd0);
        applyStimulus(10'h155, 32'hC3C3_3C3C);
        waitValid(lat);
        checkOutput("t5_next_latency", 32'(lat), 32'd21);
        checkOutput("t5_next_write", rspWrite, 32'hC3C3_3C3C);
        checkOutput("t5_next_clean", rspClean, 32'h0);
        handshake();

        // Reset during the clean sample of round 3
        applyStimulus(10'h2AA, 32'hDEAD_BEEF);
        repeat (11) @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("t6_ready", 32'(ready), 32'd1);
        checkOutput("t6_valid", 32'(rspValid), 32'd0);
        checkOutput("t6_we", 32'(bramWe), 32'd0);
        checkOutput("t6_addr", 32'(bramAddr), 32'd0);
        checkOutput("t6_din", bramDin, 32'd0);
        checkOutput("t6_write", rspWrite, 32'd0);
        checkOutput("t6_clean", rspClean, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(10'h2AA, 32'hDEAD_BEEF);
        waitValid(lat);
        checkOutput("t6_next_latency", 32'(lat), 32'd21);
        checkOutput("t6_next_write", rspWrite, 32'hDEAD_BEEF);
        checkOutput("t6_next_clean", rspClean, 32'h0);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
